// File: rtl/seg7_pkg.sv
// Shared seven-segment types and gfedcba decode constants.
// Segment codes are active-high; polarity is applied at the pins.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_0    = 7'b0111111;
  localparam seg7_t SEG7_1    = 7'b0000110;
  localparam seg7_t SEG7_2    = 7'b1011011;
  localparam seg7_t SEG7_3    = 7'b1001111;
  localparam seg7_t SEG7_4    = 7'b1100110;
  localparam seg7_t SEG7_5    = 7'b1101101;
  localparam seg7_t SEG7_6    = 7'b1111101;
  localparam seg7_t SEG7_7    = 7'b0000111;
  localparam seg7_t SEG7_8    = 7'b1111111;
  localparam seg7_t SEG7_9    = 7'b1101111;
  localparam seg7_t SEG7_DASH = 7'b1000000;
  localparam seg7_t SEG7_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus: BCD capture side plus multiplexed segment/anode pins.
// The driver is the slave; whoever feeds BCD digits is the master.
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int DIGITS = 2
);

  logic [4*DIGITS-1:0] din;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  seg7_t               seg;
  logic                dp_out;
  logic [DIGITS-1:0]   an;

  modport master (
    output din, dp_in, load,
    input  seg, dp_out, an
  );

  modport slave (
    input  din, dp_in, load,
    output seg, dp_out, an
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high gfedcba segment decoder.
// Non-BCD codes 10..15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG7_DASH;
    unique case (bcd)
      4'd0:    seg = SEG7_0;
      4'd1:    seg = SEG7_1;
      4'd2:    seg = SEG7_2;
      4'd3:    seg = SEG7_3;
      4'd4:    seg = SEG7_4;
      4'd5:    seg = SEG7_5;
      4'd6:    seg = SEG7_6;
      4'd7:    seg = SEG7_7;
      4'd8:    seg = SEG7_8;
      4'd9:    seg = SEG7_9;
      default: seg = SEG7_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with registered outputs.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic INV = (SEG_ACTIVE_LOW != 0);

  localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic [DIGITS-1:0][3:0]  disp;
  logic [DIGITS-1:0]       dpr;
  logic [3:0]              cur;
  seg7_t                   dec;
  logic                    blank;

  assign cur = disp[idx];

  bcd_to_seg7 u_dec (
    .bcd (cur),
    .seg (dec)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;

  // Digit i is a leading zero when it and all digits above it are 0.
  always_comb begin
    logic z;
    lz = '0;
    z  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z     = z & (disp[i] == 4'd0);
      lz[i] = z;
    end
  end

  assign blank = lz[idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt       <= '0;
      idx        <= '0;
      disp       <= '0;
      dpr        <= '0;
      bus.an     <= {DIGITS{INV}};
      bus.seg    <= SEG7_OFF ^ {7{INV}};
      bus.dp_out <= INV;
    end else begin
      if (bus.load) begin
        disp <= bus.din;
        dpr  <= bus.dp_in;
      end
      if (pcnt == PLAST) begin
        pcnt <= '0;
        idx  <= (idx == ILAST) ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      // Outputs reflect the pre-edge digit index and display register.
      if (blank) begin
        bus.an     <= {DIGITS{INV}};
        bus.seg    <= SEG7_OFF ^ {7{INV}};
        bus.dp_out <= INV;
      end else begin
        bus.an     <= (DIGITS'(1) << idx) ^ {DIGITS{INV}};
        bus.seg    <= dec ^ {7{INV}};
        bus.dp_out <= dpr[idx] ^ INV;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: active-high and active-low instances
// driven in lockstep and checked against a frame-time reference model.
module tb_seg7_scan_driver;

  localparam int DIGITS = 2;
  localparam int SD     = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din   = '0;
  logic [1:0] dp_in = '0;
  logic       load  = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus_hi ();
  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus_lo ();

  assign bus_hi.din   = din;
  assign bus_hi.dp_in = dp_in;
  assign bus_hi.load  = load;
  assign bus_lo.din   = din;
  assign bus_lo.dp_in = dp_in;
  assign bus_lo.load  = load;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0)
  ) dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_hi)
  );

  seg7_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1)
  ) dut_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_lo)
  );

  int vecs = 0;
  int errs = 0;

  // Reference state: edges since reset release, and displayed value.
  int         cyc    = 0;
  logic [7:0] m_disp = '0;
  logic [1:0] m_dp   = '0;
  logic [6:0] tbl [16];

  // Expected {an, dp_out, seg}, active-high, for the coming edge.
  function automatic logic [9:0] model_out();
    int         i;
    logic       blank;
    logic [3:0] d;
    i     = (cyc / SD) % DIGITS;
    d     = m_disp[4*i +: 4];
    blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (i >= 1) begin
      blank = 1'b1;
      for (int j = i; j < DIGITS; j++)
        if (m_disp[4*j +: 4] != 4'd0) blank = 1'b0;
    end
`endif
    if (blank) return 10'd0;
    return {2'(1 << i), m_dp[i], tbl[d]};
  endfunction

  task automatic step(input string tag);
    logic [9:0] e;
    logic [9:0] got_hi;
    logic [9:0] got_lo;
    e = reset ? 10'd0 : model_out();
    @(posedge clk);
    if (reset) begin
      cyc    = 0;
      m_disp = '0;
      m_dp   = '0;
    end else begin
      cyc++;
      if (load) begin
        m_disp = din;
        m_dp   = dp_in;
      end
    end
    #1;
    got_hi = {bus_hi.an, bus_hi.dp_out, bus_hi.seg};
    got_lo = {bus_lo.an, bus_lo.dp_out, bus_lo.seg};
    vecs++;
    assert (got_hi === e) else begin
      errs++;
      $error("FAIL %s hi: {an,dp,seg} got %b want %b", tag, got_hi, e);
    end
    vecs++;
    assert (got_lo === ~e) else begin
      errs++;
      $error("FAIL %s lo: {an,dp,seg} got %b want %b", tag, got_lo, ~e);
    end
  endtask

  initial begin
    tbl[0]  = 7'b0111111; tbl[1]  = 7'b0000110;
    tbl[2]  = 7'b1011011; tbl[3]  = 7'b1001111;
    tbl[4]  = 7'b1100110; tbl[5]  = 7'b1101101;
    tbl[6]  = 7'b1111101; tbl[7]  = 7'b0000111;
    tbl[8]  = 7'b1111111; tbl[9]  = 7'b1101111;
    for (int k = 10; k < 16; k++) tbl[k] = 7'b1000000;

    reset = 1'b1;
    repeat (3) step("reset");
    reset = 1'b0;

    din   = 8'h59;
    dp_in = 2'b10;
    load  = 1'b1;
    step("load59");
    load  = 1'b0;
    repeat (16) step("scan59");

    load = 1'b1;
    for (int v = 0; v < 60; v++) begin
      din   = {4'(v / 10), 4'(v % 10)};
      dp_in = 2'($urandom);
      step("ripple");
    end

    for (int k = 0; k < 120; k++) begin
      din   = 8'($urandom);
      dp_in = 2'($urandom);
      load  = ($urandom % 3) != 0;
      step("random");
    end

    din   = 8'h3C;
    dp_in = 2'b00;
    load  = 1'b1;
    step("load3c");
    load  = 1'b0;
    repeat (8) step("illegal");

    for (int k = 0; k < SD * DIGITS; k++) begin
      if ((cyc % (SD * DIGITS)) == SD + 2) break;
      step("align");
    end
    reset = 1'b1;
    step("midrst");
    reset = 1'b0;
    repeat (12) step("restart");

    din  = 8'h07;
    load = 1'b1;
    step("load07");
    load = 1'b0;
    repeat (8) step("lead07");
    din  = 8'h00;
    load = 1'b1;
    step("load00");
    load = 1'b0;
    repeat (8) step("lead00");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
